// File: rtl/haar_cascade_sequencer_if.sv
// Purpose: bundles the sequencer's start/ROM/classifier-bank signals between the window control and the stage bank.
// Latency: none (wires only); i_rom_data must be valid in the cycle o_rom_addr is presented.
// Backpressure: none; the sequencer issues one ROM word per cycle and the bank must keep up.
interface haar_cascade_sequencer_if #(
  parameter int NUM_STAGE     = 10,
  parameter int DATA_WIDTH_12 = 12,
  parameter int ADDR_WIDTH    = 16
);
  logic                                 i_start;
  logic [NUM_STAGE*DATA_WIDTH_12-1:0]   i_num_tree;
  logic [DATA_WIDTH_12-1:0]             i_rom_data;
  logic [NUM_STAGE-1:0]                 i_candidate;
  logic [ADDR_WIDTH-1:0]                o_rom_addr;
  logic [DATA_WIDTH_12-1:0]             o_data;
  logic                                 o_data_valid;
  logic [DATA_WIDTH_12-1:0]             o_index_database;
  logic [DATA_WIDTH_12-1:0]             o_index_classifier;
  logic [DATA_WIDTH_12-1:0]             o_index_tree;
  logic [NUM_STAGE-1:0]                 o_end_single_classifier;
  logic [NUM_STAGE-1:0]                 o_end_tree;
  logic [NUM_STAGE-1:0]                 o_end_database;
  logic [NUM_STAGE-1:0]                 o_stage_sel;
  logic                                 o_busy;
  logic                                 o_inspect_done;
  logic                                 o_face;

  modport master (
    input  i_start, i_num_tree, i_rom_data, i_candidate,
    output o_rom_addr, o_data, o_data_valid, o_index_database, o_index_classifier,
           o_index_tree, o_end_single_classifier, o_end_tree, o_end_database,
           o_stage_sel, o_busy, o_inspect_done, o_face
  );

  modport slave (
    output i_start, i_num_tree, i_rom_data, i_candidate,
    input  o_rom_addr, o_data, o_data_valid, o_index_database, o_index_classifier,
           o_index_tree, o_end_single_classifier, o_end_tree, o_end_database,
           o_stage_sel, o_busy, o_inspect_done, o_face
  );
endinterface

// File: rtl/haar_cascade_sequencer.sv
// Purpose: walks the contiguous Haar database stage by stage for one window and collects per-stage pass flags.
// Latency: words appear one cycle after their address; each stage adds RESULT_LATENCY+1 wait cycles; done 2 cycles after start if all stages are empty.
// Backpressure: none; i_start is ignored unless idle. Macro HAAR_SEQ_EARLY_REJECT_EN: first failing stage ends the cascade.
module haar_cascade_sequencer #(
  parameter int NUM_STAGE            = 10,
  parameter int DATA_WIDTH_12        = 12,
  parameter int ADDR_WIDTH           = 16,
  parameter int WORDS_PER_CLASSIFIER = 5,
  parameter int CLASSIFIERS_PER_TREE = 3,
  parameter int RESULT_LATENCY       = 2
) (
  input  logic                       clk_fpga,
  input  logic                       reset_fpga,
  haar_cascade_sequencer_if.master   bus
);
  localparam int DW  = DATA_WIDTH_12;
  localparam int SW  = (NUM_STAGE > 1) ? $clog2(NUM_STAGE) : 1;
  localparam int WCW = $clog2(RESULT_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;

  state_t                state;
  logic [SW-1:0]         stage;
  logic                  stage_ok;   // low only for the empty-database pass through FETCH
  logic [DW-1:0]         cnt_w, cnt_c, cnt_t, ntree;
  logic [WCW-1:0]        wait_cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  face_acc;

  // Lowest stage index >= from whose tree count is non-zero; MSB flags a hit.
  function automatic logic [SW:0] find_stage(input int from, input logic [NUM_STAGE*DW-1:0] nt);
    logic          found;
    logic [SW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_STAGE; i++) begin
      if (!found && i >= from && nt[DW*i +: DW] != '0) begin
        found = 1'b1;
        idx   = SW'(i);
      end
    end
    return {found, idx};
  endfunction

  logic [SW:0]          first_hit, next_hit;
  logic [SW-1:0]        first_idx, next_idx;
  logic [NUM_STAGE-1:0] stage_1h;
  logic                 last_w, last_c, last_t;
  logic                 pass_now, reject_now;

  assign first_hit = find_stage(0, bus.i_num_tree);
  assign next_hit  = find_stage(int'(stage) + 1, bus.i_num_tree);
  assign first_idx = first_hit[SW-1:0];
  assign next_idx  = next_hit[SW-1:0];
  assign stage_1h  = NUM_STAGE'(1) << stage;
  assign last_w    = (cnt_w == DW'(WORDS_PER_CLASSIFIER - 1));
  assign last_c    = (cnt_c == DW'(CLASSIFIERS_PER_TREE - 1));
  assign last_t    = (cnt_t == ntree - 1'b1);
  assign pass_now  = face_acc & bus.i_candidate[stage];
`ifdef HAAR_SEQ_EARLY_REJECT_EN
  assign reject_now = ~bus.i_candidate[stage];
`else
  assign reject_now = 1'b0;
`endif

  // The address counter itself drives the ROM; it only moves while fetching.
  assign bus.o_rom_addr = addr;

  // Cascade FSM with word counters and the one-cycle data/strobe pipeline.
  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      state                       <= IDLE;
      stage                       <= '0;
      stage_ok                    <= 1'b0;
      cnt_w                       <= '0;
      cnt_c                       <= '0;
      cnt_t                       <= '0;
      ntree                       <= '0;
      wait_cnt                    <= '0;
      addr                        <= '0;
      face_acc                    <= 1'b0;
      bus.o_data                  <= '0;
      bus.o_data_valid            <= 1'b0;
      bus.o_index_database        <= '0;
      bus.o_index_classifier      <= '0;
      bus.o_index_tree            <= '0;
      bus.o_end_single_classifier <= '0;
      bus.o_end_tree              <= '0;
      bus.o_end_database          <= '0;
      bus.o_stage_sel             <= '0;
      bus.o_busy                  <= 1'b0;
      bus.o_inspect_done          <= 1'b0;
      bus.o_face                  <= 1'b0;
    end else begin
      bus.o_data                  <= '0;
      bus.o_data_valid            <= 1'b0;
      bus.o_index_database        <= '0;
      bus.o_index_classifier      <= '0;
      bus.o_index_tree            <= '0;
      bus.o_end_single_classifier <= '0;
      bus.o_end_tree              <= '0;
      bus.o_end_database          <= '0;
      bus.o_inspect_done          <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            state       <= FETCH;
            addr        <= '0;
            cnt_w       <= '0;
            cnt_c       <= '0;
            cnt_t       <= '0;
            face_acc    <= 1'b1;
            bus.o_face  <= 1'b0;
            bus.o_busy  <= 1'b1;
            stage       <= first_idx;
            stage_ok    <= first_hit[SW];
            ntree       <= first_hit[SW] ? bus.i_num_tree[DW*first_idx +: DW] : '0;
            bus.o_stage_sel <= first_hit[SW] ? (NUM_STAGE'(1) << first_idx) : '0;
          end
        end
        FETCH: begin
          if (!stage_ok) begin
            state              <= DONE;
            bus.o_face         <= 1'b1;
            bus.o_inspect_done <= 1'b1;
            bus.o_stage_sel    <= '0;
          end else begin
            bus.o_data                  <= bus.i_rom_data;
            bus.o_data_valid            <= 1'b1;
            bus.o_index_database        <= cnt_w;
            bus.o_index_classifier      <= cnt_c;
            bus.o_index_tree            <= cnt_t;
            bus.o_end_single_classifier <= last_w ? stage_1h : '0;
            bus.o_end_tree              <= (last_w && last_c) ? stage_1h : '0;
            bus.o_end_database          <= (last_w && last_c && last_t) ? stage_1h : '0;
            addr                        <= addr + 1'b1;
            if (last_w) begin
              cnt_w <= '0;
              if (last_c) begin
                cnt_c <= '0;
                if (last_t) begin
                  cnt_t    <= '0;
                  wait_cnt <= '0;
                  state    <= WAIT;
                end else begin
                  cnt_t <= cnt_t + 1'b1;
                end
              end else begin
                cnt_c <= cnt_c + 1'b1;
              end
            end else begin
              cnt_w <= cnt_w + 1'b1;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == WCW'(RESULT_LATENCY)) begin
            face_acc <= pass_now;
            if (reject_now || !next_hit[SW]) begin
              state              <= DONE;
              bus.o_face         <= pass_now;
              bus.o_inspect_done <= 1'b1;
              bus.o_stage_sel    <= '0;
            end else begin
              state           <= FETCH;
              stage           <= next_idx;
              ntree           <= bus.i_num_tree[DW*next_idx +: DW];
              bus.o_stage_sel <= NUM_STAGE'(1) << next_idx;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          bus.o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_haar_cascade_sequencer.sv
// Purpose: directed and randomized windows against a word-list model of the cascade walk.
// Latency: checks word order, strobes, done cycle and face result for each window.
// Backpressure: the bench plays ROM and classifier bank; candidates are valid only in the sampling cycle.
module tb_haar_cascade_sequencer;
  localparam int NS  = 3;
  localparam int RL  = 2;
  localparam int WPC = 5;
  localparam int CPT = 3;

  typedef struct packed {
    logic [2:0]  sel;
    logic [11:0] data;
    logic [11:0] idb;
    logic [11:0] icl;
    logic [11:0] itr;
    logic [2:0]  esc;
    logic [2:0]  etr;
    logic [2:0]  edb;
  } word_t;

  typedef struct packed {
    int   cyc;
    logic face;
  } done_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;
  logic [11:0] rom_key;
  logic [NS-1:0] cand_want;
  int   cd [NS];

  word_t        obs_q[$];
  word_t        exp_q[$];
  done_t        done_q[$];
  logic [NS-1:0] sel_q[$];

  haar_cascade_sequencer_if #(.NUM_STAGE(NS), .DATA_WIDTH_12(12), .ADDR_WIDTH(16)) bus();

  haar_cascade_sequencer #(
    .NUM_STAGE(NS), .DATA_WIDTH_12(12), .ADDR_WIDTH(16),
    .WORDS_PER_CLASSIFIER(WPC), .CLASSIFIERS_PER_TREE(CPT), .RESULT_LATENCY(RL)
  ) dut (
    .clk_fpga(clk),
    .reset_fpga(rst_n),
    .bus(bus)
  );

  function automatic logic [11:0] rom_fn(input logic [15:0] a);
    logic [15:0] x;
    x = a * 16'd113 + 16'd29;
    return x[11:0];
  endfunction

  assign bus.i_rom_data = rom_fn(bus.o_rom_addr) ^ rom_key;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor plus classifier-bank stand-in: candidate bit s carries the wanted value only
  // in the cycle exactly RL cycles after that stage's end_database strobe.
  initial begin
    word_t rec;
    done_t dn;
    bus.i_candidate = '0;
    for (int s = 0; s < NS; s++) cd[s] = -1;
    forever begin
      @(negedge clk);
      sel_q.push_back(bus.o_stage_sel);
      if (bus.o_data_valid) begin
        rec.sel  = bus.o_stage_sel;
        rec.data = bus.o_data;
        rec.idb  = bus.o_index_database;
        rec.icl  = bus.o_index_classifier;
        rec.itr  = bus.o_index_tree;
        rec.esc  = bus.o_end_single_classifier;
        rec.etr  = bus.o_end_tree;
        rec.edb  = bus.o_end_database;
        obs_q.push_back(rec);
      end
      if (bus.o_inspect_done) begin
        dn.cyc  = cyc;
        dn.face = bus.o_face;
        done_q.push_back(dn);
      end
      for (int s = 0; s < NS; s++) begin
        if (cd[s] > 0) cd[s]--;
        else if (cd[s] == 0) cd[s] = -1;
        bus.i_candidate[s] = (cd[s] == 0) ? cand_want[s] : ~cand_want[s];
        if (bus.o_end_database[s]) cd[s] = RL;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic any_output();
    return |{bus.o_rom_addr, bus.o_data, bus.o_data_valid, bus.o_index_database,
             bus.o_index_classifier, bus.o_index_tree, bus.o_end_single_classifier,
             bus.o_end_tree, bus.o_end_database, bus.o_stage_sel, bus.o_busy,
             bus.o_inspect_done, bus.o_face};
  endfunction

  // Runs one window; hold keeps i_start high through the whole cascade and its done cycle.
  task automatic run_window(input string name, input int n0, input int n1, input int n2,
                            input logic [NS-1:0] want, input bit hold);
    int nt [NS];
    int c0, n, ob, db, sb, addr, off;
    logic face, any;
    logic [NS-1:0] esel, seen;
    word_t wd;
    nt[0] = n0; nt[1] = n1; nt[2] = n2;
    bus.i_num_tree = {12'(n2), 12'(n1), 12'(n0)};
    cand_want = want;
    @(negedge clk);
    ob = obs_q.size(); db = done_q.size(); sb = sel_q.size();
    bus.i_start = 1'b1;
    c0 = cyc;
    if (!hold) begin
      @(negedge clk);
      bus.i_start = 1'b0;
    end
    n = 0;
    while (!bus.o_inspect_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (hold) begin
      @(negedge clk);
      bus.i_start = 1'b0;
    end
    repeat (6) @(negedge clk);

    // Reference: list every database word in walk order, then timing and result.
    exp_q.delete();
    addr = 0; off = 1; face = 1'b1; any = 1'b0; esel = '0;
    for (int s = 0; s < NS; s++) begin
      if (nt[s] == 0) continue;
      any = 1'b1;
      esel[s] = 1'b1;
      for (int t = 0; t < nt[s]; t++)
        for (int c = 0; c < CPT; c++)
          for (int w = 0; w < WPC; w++) begin
            wd.sel  = 3'(1 << s);
            wd.data = rom_fn(16'(addr)) ^ rom_key;
            wd.idb  = 12'(w);
            wd.icl  = 12'(c);
            wd.itr  = 12'(t);
            wd.esc  = (w == WPC-1) ? 3'(1 << s) : 3'b0;
            wd.etr  = (w == WPC-1 && c == CPT-1) ? 3'(1 << s) : 3'b0;
            wd.edb  = (w == WPC-1 && c == CPT-1 && t == nt[s]-1) ? 3'(1 << s) : 3'b0;
            exp_q.push_back(wd);
            addr++;
          end
      off += nt[s] * WPC * CPT + RL + 1;
      face &= want[s];
`ifdef HAAR_SEQ_EARLY_REJECT_EN
      if (!want[s]) break;
`endif
    end
    if (!any) off = 2;

    seen = '0;
    for (int i = sb; i < sel_q.size(); i++) seen |= sel_q[i];

    check({name, " word count"}, 64'(obs_q.size() - ob), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++)
      check($sformatf("%s word %0d", name, i), 64'(obs_q[ob+i]), 64'(exp_q[i]));
    check({name, " done pulses"}, 64'(done_q.size() - db), 64'd1);
    if (done_q.size() > db) begin
      check({name, " done cycle"}, 64'(done_q[db].cyc - c0), 64'(off));
      check({name, " face"}, 64'(done_q[db].face), 64'(face));
    end
    check({name, " stages selected"}, 64'(seen), 64'(esel));
    check({name, " busy after"}, 64'(bus.o_busy), 64'd0);
  endtask

  initial begin
    int n, db;
    errors = 0;
    checks = 0;
    rom_key = 12'(($urandom));
    cand_want = '1;
    rst_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_num_tree = '0;
    #1;
    check("reset outputs", 64'(any_output()), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_window("t1 two stages", 1, 2, 0, 3'b111, 1'b0);
    run_window("t2t3 stage0 rejects", 1, 1, 1, 3'b110, 1'b0);
    run_window("t4 middle stage only", 0, 1, 0, 3'b111, 1'b0);
    run_window("all empty", 0, 0, 0, 3'b000, 1'b0);
    run_window("t5 start held", 1, 0, 1, 3'b111, 1'b1);
    run_window("last stage rejects", 1, 0, 1, 3'b011, 1'b0);

    for (int r = 0; r < 4; r++) begin
      rom_key = 12'($urandom);
      run_window($sformatf("random %0d", r), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                 3'($urandom), 1'b0);
    end

    // Abort mid-fetch: reset acts immediately and the window never reports done.
    bus.i_num_tree = {12'd0, 12'd0, 12'd2};
    cand_want = '1;
    @(negedge clk);
    db = done_q.size();
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    n = 0;
    while (bus.o_rom_addr != 16'd7 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6 reached addr 7", 64'(bus.o_rom_addr), 64'd7);
    rst_n = 1'b0;
    #1;
    check("t6 outputs cleared", 64'(any_output()), 64'd0);
    repeat (4) @(negedge clk);
    check("t6 no done", 64'(done_q.size() - db), 64'd0);
    rst_n = 1'b1;
    run_window("t6 restart", 1, 0, 0, 3'b111, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
